// File: rtl/loop_count_ctrl_if.sv
// loop_count_ctrl_if
//   Bundles the handshake between the instruction control logic and the
//   loop counter sequencer.
//   master: drives start/count_in/step/abort and observes the status outputs
//           (instruction control side, or a testbench).
//   slave : the loop_count_ctrl block itself.
//   Signals:
//     start    - load count_in and begin a loop (honoured only when idle)
//     count_in - trip count to load
//     step     - request one iteration (honoured only while running)
//     abort    - cancel the running loop (wins over step)
//     busy     - loop is running
//     count    - current counter register value
//     is_zero  - count == 0
//     iter     - one-cycle pulse after each accepted step
//     done     - one-cycle pulse when the loop completes
//     aborted  - one-cycle pulse after an accepted abort
interface loop_count_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] count_in;
  logic             step;
  logic             abort;
  logic             busy;
  logic [WIDTH-1:0] count;
  logic             is_zero;
  logic             iter;
  logic             done;
  logic             aborted;

  modport master (
    output start, count_in, step, abort,
    input  busy, count, is_zero, iter, done, aborted
  );

  modport slave (
    input  start, count_in, step, abort,
    output busy, count, is_zero, iter, done, aborted
  );
endinterface

// File: rtl/loop_count_ctrl.sv
// loop_count_ctrl
//   Sequences an unsigned WIDTH-bit loop counter through a down-count.
//   A start in IDLE loads the trip count; each accepted step in RUN
//   decrements it, and reaching zero ends the loop with a one-cycle done
//   pulse. A zero trip count goes straight to DONE without ever running.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     ctl   - loop_count_ctrl_if slave modport (start/count_in/step/abort
//             in, busy/count/is_zero/iter/done/aborted out)
module loop_count_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  loop_count_ctrl_if.slave    ctl
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic             iter_q;
  logic             aborted_q;

  // Single registered FSM. iter and aborted default low so each can only
  // be high for the one cycle after the event that caused it. The
  // decrement is only reachable in RUN where count is at least 1, so the
  // counter can never wrap from zero to all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count_q   <= '0;
      iter_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      iter_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state)
        IDLE: begin
          if (ctl.start) begin
            count_q <= ctl.count_in;
            state   <= (ctl.count_in == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (ctl.abort) begin
            state     <= IDLE;
            aborted_q <= 1'b1;
          end else if (ctl.step) begin
            count_q <= count_q - WIDTH'(1);
            iter_q  <= 1'b1;
            if (count_q == WIDTH'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          // count is already zero on every path into DONE; forcing it
          // keeps the invariant explicit.
          count_q <= '0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status outputs decode the state register directly, so they change
  // only on clock edges (or reset) and need no extra flops.
  assign ctl.busy    = (state == RUN);
  assign ctl.done    = (state == DONE);
  assign ctl.count   = count_q;
  assign ctl.is_zero = (count_q == '0);
  assign ctl.iter    = iter_q;
  assign ctl.aborted = aborted_q;

endmodule

// File: tb/tb_loop_count_ctrl.sv
// tb_loop_count_ctrl
//   Drives loop_count_ctrl through directed scenarios and random traffic,
//   comparing every output each cycle against a behavioural model that
//   tracks the loop as "remaining iterations" plus pending pulses.
module tb_loop_count_ctrl;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;

  loop_count_ctrl_if #(.WIDTH(WIDTH)) bus ();

  loop_count_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: remaining trip count, whether a loop is running,
  // whether the completion cycle is being shown, and pending pulses.
  int m_remaining = 0;
  bit m_running   = 0;
  bit m_finishing = 0;
  bit m_iter      = 0;
  bit m_aborted   = 0;

  int exp_iter_total = 0;
  int exp_done_total = 0;
  int exp_abort_total = 0;
  int obs_iter_total = 0;
  int obs_done_total = 0;
  int obs_abort_total = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Compare all DUT outputs with the model's view of the current cycle.
  task automatic compareModel();
    checkOutput("count",   32'(bus.count),   32'(m_remaining));
    checkOutput("is_zero", 32'(bus.is_zero), 32'(m_remaining == 0));
    checkOutput("busy",    32'(bus.busy),    32'(m_running));
    checkOutput("done",    32'(bus.done),    32'(m_finishing));
    checkOutput("iter",    32'(bus.iter),    32'(m_iter));
    checkOutput("aborted", 32'(bus.aborted), 32'(m_aborted));
    if (bus.iter === 1'b1)    obs_iter_total++;
    if (bus.done === 1'b1)    obs_done_total++;
    if (bus.aborted === 1'b1) obs_abort_total++;
  endtask

  // At the falling edge: check the cycle just produced, drive the next
  // inputs, and predict what the following rising edge will produce.
  task automatic applyStimulus(input bit s, input int ci, input bit st,
                               input bit ab);
    @(negedge clk);
    compareModel();
    bus.start    = s;
    bus.count_in = WIDTH'(ci);
    bus.step     = st;
    bus.abort    = ab;
    m_iter    = 0;
    m_aborted = 0;
    if (m_finishing) begin
      m_finishing = 0;
    end else if (m_running) begin
      if (ab) begin
        m_running = 0;
        m_aborted = 1;
        exp_abort_total++;
      end else if (st) begin
        m_remaining = m_remaining - 1;
        m_iter = 1;
        exp_iter_total++;
        if (m_remaining == 0) begin
          m_running   = 0;
          m_finishing = 1;
          exp_done_total++;
        end
      end
    end else if (s) begin
      m_remaining = ci % (1 << WIDTH);
      if (m_remaining == 0) begin
        m_finishing = 1;
        exp_done_total++;
      end else begin
        m_running = 1;
      end
    end
  endtask

  task automatic modelReset();
    m_remaining = 0;
    m_running   = 0;
    m_finishing = 0;
    m_iter      = 0;
    m_aborted   = 0;
  endtask

  // Assert reset mid-cycle and confirm the outputs clear without waiting
  // for a clock edge.
  task automatic asyncReset(input string tag);
    @(negedge clk);
    compareModel();
    bus.start = 0;
    bus.step  = 0;
    bus.abort = 0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput({tag, "_count"},   32'(bus.count),   32'd0);
    checkOutput({tag, "_is_zero"}, 32'(bus.is_zero), 32'd1);
    checkOutput({tag, "_busy"},    32'(bus.busy),    32'd0);
    checkOutput({tag, "_done"},    32'(bus.done),    32'd0);
    checkOutput({tag, "_iter"},    32'(bus.iter),    32'd0);
    checkOutput({tag, "_aborted"}, 32'(bus.aborted), 32'd0);
    modelReset();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  int done_before;
  int iter_before;

  initial begin
    rst_n        = 1'b0;
    bus.start    = 0;
    bus.count_in = '0;
    bus.step     = 0;
    bus.abort    = 0;
    #3;
    checkOutput("por_count",   32'(bus.count),   32'd0);
    checkOutput("por_is_zero", 32'(bus.is_zero), 32'd1);
    checkOutput("por_busy",    32'(bus.busy),    32'd0);
    checkOutput("por_done",    32'(bus.done),    32'd0);
    modelReset();
    @(negedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] basic loop of 3");
    applyStimulus(1, 3, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0);

    $display("[TB] zero-trip loop");
    applyStimulus(1, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);

    $display("[TB] 255 steps with gaps and start held");
    done_before = exp_done_total;
    iter_before = obs_iter_total;
    applyStimulus(1, 255, 0, 0);
    for (int i = 0; i < 510; i++)
      applyStimulus(1, int'($urandom_range(0, 255)), (i % 2) == 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("ff_done_pulses", 32'(obs_done_total - done_before), 32'd1);
    checkOutput("ff_iter_pulses", 32'(obs_iter_total - iter_before), 32'd255);

    $display("[TB] abort beats step");
    applyStimulus(1, 5, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);

    $display("[TB] reset in the middle of a loop");
    applyStimulus(1, 10, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);
    asyncReset("midloop");
    done_before = obs_done_total;
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("after_reset_done", 32'(obs_done_total - done_before), 32'd1);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 2) == 0,
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, 6)),
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 11) == 0);
      if (i == 300) asyncReset("random");
    end
    applyStimulus(0, 0, 0, 0);

    checkOutput("iter_total",  32'(obs_iter_total),  32'(exp_iter_total));
    checkOutput("done_total",  32'(obs_done_total),  32'(exp_done_total));
    checkOutput("abort_total", 32'(obs_abort_total), 32'(exp_abort_total));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/loop_count_ctrl.md
Name: loop_count_ctrl

Overview:
- Sequences the toy processor's 8-bit loop counter through a down-count and uses the zero-detect condition to end the loop.
- Loads a trip count, decrements once per accepted step, flags zero and signals completion.
- Sits between the instruction control logic (start/step/abort) and the counter/zero-detect datapath.
- Provides the registered zero flag and done/iteration pulses that branch logic consumes.

Parameters:
- WIDTH, 8, counter and trip-count width in bits; all arithmetic is unsigned WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- start  input  1  load count_in and begin a loop; sampled only in IDLE
- count_in  input  WIDTH  trip count to load
- step  input  1  request one iteration (decrement); sampled only in RUN
- abort  input  1  cancel the loop; sampled only in RUN
- busy  output  1  high while in RUN
- count  output  WIDTH  current counter register value
- is_zero  output  1  high when count == 0 (combinational from the count register)
- iter  output  1  one-cycle pulse, registered, after each accepted step
- done  output  1  one-cycle pulse, high while state == DONE
- aborted  output  1  one-cycle pulse, registered, after an accepted abort

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE, count=0, iter=0, done=0, aborted=0.
  - Outputs settle to busy=0 and is_zero=1.
  - Reset mid-loop discards all progress; no done or aborted pulse is produced.
- State machine: IDLE, RUN, DONE. Encoding is free; no illegal state may persist (default to IDLE).
- IDLE:
  - busy=0. count holds its value.
  - start=1 at the clock edge: count<=count_in.
  - Next state is DONE if count_in==0 (zero-trip loop), otherwise RUN.
  - step and abort are ignored.
- RUN:
  - busy=1.
  - Priority: abort > step.
  - abort=1: next state IDLE, count holds, aborted=1 in the following cycle, no done pulse.
  - step=1 with abort=0:
    - count<=count-1, and iter=1 in the following cycle, aligned with the decremented count.
    - If count==1 before the edge, next state is DONE; otherwise stay in RUN.
  - step=0 and abort=0: hold state and count.
  - start is ignored.
- DONE:
  - done=1 for exactly one cycle, busy=0, count=0, is_zero=1.
  - Next state is IDLE unconditionally.
  - start is ignored in DONE; it must be re-asserted in IDLE.
- Latency:
  - start to busy: 1 cycle.
  - Last accepted step to done: 1 cycle.
  - A loop of N>0 iterations with step held high takes N cycles in RUN, then 1 cycle in DONE.
  - Zero-trip: start to done is 1 cycle, and busy never asserts.
- Wrap-around: not possible. Decrement happens only in RUN, where count>=1. count never passes from 0 to all-ones.
- Pulses:
  - iter, done and aborted never exceed one cycle per event.
  - iter and done are both high in the cycle after the final step.
  - aborted is mutually exclusive with done and iter.
- Max trip count is 2^WIDTH-1 (255 at default width).

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle -> immediately count=0, is_zero=1, busy=0, done=0, iter=0, aborted=0.
- Basic loop: count_in=3, start pulse, step held 1 -> count goes 3,2,1,0 on successive cycles. busy is 1 for 3 cycles, iter pulses 3 times, done=1 for the single cycle where count=0, then IDLE.
- Zero-trip: count_in=0, start -> next cycle done=1, busy never 1, iter never 1, is_zero=1.
- Step gaps and start masking: count_in=8'hFF, step toggled 1/0, start=1 throughout RUN -> count decrements only on step cycles and start has no effect.
  - Exhaustive run of 255 steps ends with one done pulse and no wrap to 8'hFF.
- Abort priority: count_in=5, two steps (count=3), then abort=1 and step=1 in the same cycle -> count stays 3, aborted=1 for one cycle, no iter, no done, state IDLE.
- Reset mid-loop: count_in=10, three steps, then rst_n=0 -> count=0, busy=0, no done pulse.
  - After release, a new start with count_in=1 runs exactly one iteration and produces one done.
